sni_pattern_scanner: RTL and testbench
======================================

# sni_pattern_scanner

Per-flow payload pattern scanner sitting directly downstream of the BRAM data mover in the SNI pattern-match path. It consumes the mover's 64-bit beat stream (five packets per flow, 32 beats per packet) and slides a fixed byte pattern across each packet's payload, including matches that straddle beat boundaries. After the last packet of a flow it emits one summary record: hit flag, per-packet hit mask, match count and first-match position.

## Interface
- PATTERN, 64'h160301_0000000000, pattern bytes left-justified (byte 0 in [63:56])
- PAT_LEN, 3, active pattern bytes, legal 1..8
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low (one clock; sync active-low reset, fixed)
- i_pkt_data_valid  in  1  beat qualifier
- i_pkt_data  in  64  beat data, payload byte 0 of beat in [63:56]
- i_pkt_len  in  8  payload bytes of current packet, stable from beat 2 to 32
- i_pkt_num  in  3  packet index in flow, 0..4
- i_pkt_protocol  in  8  IP protocol of current packet
- i_pkt_cycle_cnt  in  6  beat index 1..32 (1 = metadata beat, 2..32 = payload)
- i_flow_id  in  8  flow identifier
- o_match_valid  out  1  one-cycle record strobe
- o_match_flow_id  out  8  flow of record
- o_match_hit  out  1  at least one match in flow
- o_match_pkt_mask  out  5  bit n = match in packet n
- o_match_cnt  out  8  total matches in flow, saturating at 255
- o_match_first_pkt  out  3  packet of first match
- o_match_first_off  out  8  payload byte offset of first pattern byte of first match

## Operation
- FSM: IDLE -> SCAN on valid beat with cycle_cnt==1 and pkt_num==0 (latch flow_id, clear accumulators); SCAN -> FLUSH on valid beat 32 with pkt_num==4; FLUSH -> REPORT (pipeline drain); REPORT -> IDLE, pulse o_match_valid.
- Payload beat b (cycle_cnt 2..32) carries payload bytes 8*(b-2)..8*(b-2)+7; max 248 bytes. i_pkt_len latched on beat 2.
- Window = previous beat's last 7 bytes ++ current 8 bytes; 8 compare alignments, each ending a candidate match inside the current beat. Previous-beat bytes forced invalid at beat 2 (no cross-packet matches).
- A match counts only if all PAT_LEN bytes have offset < latched pkt_len. Multiple/overlapping matches per beat all count (popcount added, saturating).
- First match = lowest pkt_num, then lowest offset; recorded once per flow.
- Beat with cycle_cnt==1 and pkt_num==0 while in SCAN/FLUSH: abandon current flow, no record, restart with new flow_id.
- Valid low or cycle_cnt==0 mid-packet: packet truncated, bytes received so far stay scanned; next cycle_cnt==1 beat resumes normally.
- Packet with pkt_num not matching expected sequence: ignored (no scan).

## Timing
- Reset: all outputs 0, FSM IDLE, accumulators cleared; reset mid-flow drops flow, no record.
- Stage 1: register beat + window; stage 2: compare/popcount/accumulate.
- Last beat (pkt 4, beat 32) accepted at cycle T -> o_match_valid high exactly cycle T+2 for one cycle; record fields held until next record.
- A new flow's beat 1 at T+1 or T+2 is accepted; its accumulators are separate from the record being reported.
- Throughput: one beat per clock, no backpressure.

## Configuration
- SNI_SCAN_TCP_ONLY_EN defined: packets with i_pkt_protocol != 8'd6 are not scanned (mask bit 0, no count), but still advance the flow sequence.
- Undefined: all protocols scanned.

## Test plan
- Pkt 0 payload starts 16 03 01, len 200, others no match -> record: hit 1, mask 5'b00001, cnt 1, first_pkt 0, first_off 0, at T+2.
- Pattern at offsets 6..8 of pkt 2 (straddles beats 2/3) -> mask 5'b00100, first_off 6.
- Pattern at offset 198 of pkt 1 with len 200 -> not counted; hit 0, mask 0, cnt 0.
- Pattern in every packet twice -> mask 5'b11111, cnt 10, first_pkt 0.
- New flow beat 1 (pkt_num 0) injected during pkt 3, and i_rst_n low mid-flow -> no record for abandoned flow; next full flow reports its own id.
- With SNI_SCAN_TCP_ONLY_EN, pattern only in pkt 0 with protocol 17 -> hit 0; without macro -> hit 1, mask 5'b00001.

Source files
------------

// File: rtl/sni_pattern_scanner.sv
// sni_pattern_scanner: slides PATTERN over each payload of a 5-packet flow and emits one summary record per flow.
// Latency: record strobe two cycles after the flow's last beat; stage 1 registers window, stage 2 compares/accumulates.
// Backpressure: none, one beat per clock; define SNI_SCAN_TCP_ONLY_EN to scan only protocol 6 packets.
module sni_pattern_scanner #(
  parameter logic [63:0] PATTERN = 64'h160301_0000000000,
  parameter int          PAT_LEN = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pkt_data_valid,
  input  logic [63:0] i_pkt_data,
  input  logic [7:0]  i_pkt_len,
  input  logic [2:0]  i_pkt_num,
  input  logic [7:0]  i_pkt_protocol,
  input  logic [5:0]  i_pkt_cycle_cnt,
  input  logic [7:0]  i_flow_id,
  output logic        o_match_valid,
  output logic [7:0]  o_match_flow_id,
  output logic        o_match_hit,
  output logic [4:0]  o_match_pkt_mask,
  output logic [7:0]  o_match_cnt,
  output logic [2:0]  o_match_first_pkt,
  output logic [7:0]  o_match_first_off
);

  localparam int WIN_BYTES = 15;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, REPORT} state_t;

  typedef struct packed {
    logic         vld;
    logic [2:0]   pkt;
    logic [7:0]   base;
    logic [14:0]  bvld;
    logic [119:0] win;
  } beat_t;

  typedef struct packed {
    logic [4:0] mask;
    logic [7:0] cnt;
    logic       first_vld;
    logic [2:0] first_pkt;
    logic [7:0] first_off;
  } acc_t;

  state_t      state, state_nxt;

  logic        pkt_active;
  logic [2:0]  cur_pkt;
  logic [2:0]  exp_pkt;
  logic [5:0]  nxt_beat;
  logic        pkt_scan;
  logic [7:0]  len_q;
  logic [55:0] prev_tail;
  logic [7:0]  flow_q;

  logic        flow_start;
  logic        seq_start;
  logic        beat_acc;
  logic        last_beat;
  logic        proto_ok;
  logic [7:0]  len_eff;
  logic [7:0]  base;
  logic [7:0]  byte_off;
  logic [14:0] bvld;

  beat_t       s1;
  acc_t        acc, acc_nxt;
  logic [7:0]  match;
  logic [3:0]  hit_cnt;
  logic [2:0]  first_a;
  logic [8:0]  cnt_sum;

`ifdef SNI_SCAN_TCP_ONLY_EN
  assign proto_ok = (i_pkt_protocol == 8'd6);
`else
  logic unused_proto;
  assign proto_ok     = 1'b1;
  assign unused_proto = ^i_pkt_protocol;
`endif

  assign flow_start = i_pkt_data_valid && (i_pkt_cycle_cnt == 6'd1) && (i_pkt_num == 3'd0);
  assign seq_start  = (state == SCAN) && i_pkt_data_valid && (i_pkt_cycle_cnt == 6'd1)
                      && (i_pkt_num == exp_pkt) && (i_pkt_num < 3'd5) && !flow_start;
  assign beat_acc   = (state == SCAN) && pkt_active && i_pkt_data_valid
                      && (i_pkt_cycle_cnt == nxt_beat) && (i_pkt_num == cur_pkt);
  assign last_beat  = beat_acc && (i_pkt_cycle_cnt == 6'd32) && (cur_pkt == 3'd4);
  assign len_eff    = (i_pkt_cycle_cnt == 6'd2) ? i_pkt_len : len_q;
  assign base       = {i_pkt_cycle_cnt[4:0], 3'b000} - 8'd16;

  // Window byte j holds payload offset base+j-7; bytes 0..6 come from the previous beat.
  always_comb begin
    byte_off = '0;
    bvld     = '0;
    for (int j = 0; j < WIN_BYTES; j++) begin
      byte_off = base + 8'(j) - 8'd7;
      bvld[j]  = (byte_off < len_eff) && ((j >= 7) || (i_pkt_cycle_cnt != 6'd2));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pkt_active <= 1'b0;
      cur_pkt    <= '0;
      exp_pkt    <= '0;
      nxt_beat   <= '0;
      pkt_scan   <= 1'b0;
      len_q      <= '0;
      prev_tail  <= '0;
      flow_q     <= '0;
      s1         <= '0;
    end else begin
      s1.vld <= beat_acc && pkt_scan;
      if (beat_acc) begin
        s1.pkt    <= cur_pkt;
        s1.base   <= base;
        s1.bvld   <= bvld;
        s1.win    <= {prev_tail, i_pkt_data};
        prev_tail <= i_pkt_data[55:0];
        nxt_beat  <= nxt_beat + 6'd1;
        if (i_pkt_cycle_cnt == 6'd2) len_q <= i_pkt_len;
        if (i_pkt_cycle_cnt == 6'd32) pkt_active <= 1'b0;
      end else if (flow_start || seq_start) begin
        pkt_active <= 1'b1;
        cur_pkt    <= i_pkt_num;
        exp_pkt    <= i_pkt_num + 3'd1;
        nxt_beat   <= 6'd2;
        pkt_scan   <= proto_ok;
      end else begin
        pkt_active <= 1'b0;
      end
      if (flow_start) flow_q <= i_flow_id;
    end
  end

  always_comb begin
    match = '0;
    for (int a = 0; a < 8; a++) begin
      match[a] = 1'b1;
      for (int k = 0; k < PAT_LEN; k++) begin
        if (!s1.bvld[8 + a - PAT_LEN + k] ||
            (s1.win[8*(14 - (8 + a - PAT_LEN + k)) +: 8] != PATTERN[8*(7 - k) +: 8]))
          match[a] = 1'b0;
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    first_a = '0;
    for (int a = 7; a >= 0; a--) begin
      hit_cnt = hit_cnt + {3'b000, match[a]};
      if (match[a]) first_a = 3'(a);
    end
  end

  // Packets arrive in order and beats in offset order, so the first hit seen is the first match.
  always_comb begin
    acc_nxt = acc;
    cnt_sum = {1'b0, acc.cnt} + {5'b00000, hit_cnt};
    if (s1.vld && (match != 8'd0)) begin
      acc_nxt.mask = acc.mask | (5'b00001 << s1.pkt);
      acc_nxt.cnt  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      if (!acc.first_vld) begin
        acc_nxt.first_vld = 1'b1;
        acc_nxt.first_pkt = s1.pkt;
        acc_nxt.first_off = s1.base + {5'b00000, first_a} - 8'(PAT_LEN - 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc               <= '0;
      o_match_valid     <= 1'b0;
      o_match_flow_id   <= '0;
      o_match_hit       <= 1'b0;
      o_match_pkt_mask  <= '0;
      o_match_cnt       <= '0;
      o_match_first_pkt <= '0;
      o_match_first_off <= '0;
    end else begin
      acc           <= flow_start ? '0 : acc_nxt;
      o_match_valid <= (state == FLUSH);
      if (state == FLUSH) begin
        o_match_flow_id   <= flow_q;
        o_match_hit       <= |acc_nxt.mask;
        o_match_pkt_mask  <= acc_nxt.mask;
        o_match_cnt       <= acc_nxt.cnt;
        o_match_first_pkt <= acc_nxt.first_pkt;
        o_match_first_off <= acc_nxt.first_off;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A new flow may start while the previous one drains; the record is captured independently.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (flow_start) state_nxt = SCAN;
      SCAN:    if (last_beat)  state_nxt = FLUSH;
      FLUSH:   state_nxt = flow_start ? SCAN : REPORT;
      REPORT:  state_nxt = flow_start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sni_pattern_scanner.sv
// Bench for sni_pattern_scanner: directed and random flows against a byte-search reference model.
module tb_sni_pattern_scanner;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pkt_data_valid;
  logic [63:0] i_pkt_data;
  logic [7:0]  i_pkt_len;
  logic [2:0]  i_pkt_num;
  logic [7:0]  i_pkt_protocol;
  logic [5:0]  i_pkt_cycle_cnt;
  logic [7:0]  i_flow_id;
  logic        o_match_valid;
  logic [7:0]  o_match_flow_id;
  logic        o_match_hit;
  logic [4:0]  o_match_pkt_mask;
  logic [7:0]  o_match_cnt;
  logic [2:0]  o_match_first_pkt;
  logic [7:0]  o_match_first_off;

  sni_pattern_scanner dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pkt_data_valid(i_pkt_data_valid),
    .i_pkt_data(i_pkt_data), .i_pkt_len(i_pkt_len), .i_pkt_num(i_pkt_num),
    .i_pkt_protocol(i_pkt_protocol), .i_pkt_cycle_cnt(i_pkt_cycle_cnt), .i_flow_id(i_flow_id),
    .o_match_valid(o_match_valid), .o_match_flow_id(o_match_flow_id), .o_match_hit(o_match_hit),
    .o_match_pkt_mask(o_match_pkt_mask), .o_match_cnt(o_match_cnt),
    .o_match_first_pkt(o_match_first_pkt), .o_match_first_off(o_match_first_off)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] fid;
    logic       hit;
    logic [4:0] mask;
    logic [7:0] cnt;
    logic [2:0] fpkt;
    logic [7:0] foff;
    int         cyc;
  } rec_t;

  localparam logic [7:0] PAT0 = 8'h16;
  localparam logic [7:0] PAT1 = 8'h03;
  localparam logic [7:0] PAT2 = 8'h01;

  rec_t       obs_q[$];
  rec_t       exp_q[$];
  rec_t       mon_r;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [7:0] pay [6][248];
  logic [7:0] plen [5];
  logic [7:0] pproto [5];
  int         pbeats [5];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_match_valid === 1'b1) begin
      mon_r.fid  = o_match_flow_id;
      mon_r.hit  = o_match_hit;
      mon_r.mask = o_match_pkt_mask;
      mon_r.cnt  = o_match_cnt;
      mon_r.fpkt = o_match_first_pkt;
      mon_r.foff = o_match_first_off;
      mon_r.cyc  = cyc;
      obs_q.push_back(mon_r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic [5:0] cc, input logic [2:0] pn, input logic [7:0] fid,
                            input logic [7:0] proto, input logic [7:0] len, input logic [63:0] dat);
    i_pkt_data_valid = 1'b1;
    i_pkt_cycle_cnt  = cc;
    i_pkt_num        = pn;
    i_flow_id        = fid;
    i_pkt_protocol   = proto;
    i_pkt_len        = len;
    i_pkt_data       = dat;
    last_cyc         = cyc;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_pkt_data_valid = 1'b0;
    i_pkt_cycle_cnt  = 6'd0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_pkt(input logic [2:0] pn, input int src, input logic [7:0] fid,
                          input logic [7:0] proto, input logic [7:0] len, input int nb);
    logic [63:0] d;
    drive_beat(6'd1, pn, fid, proto, len, {$urandom, $urandom});
    for (int b = 2; b <= nb + 1; b++) begin
      for (int i = 0; i < 8; i++) d[63-8*i -: 8] = pay[src][8*(b-2)+i];
      drive_beat(6'(b), pn, fid, proto, len, d);
    end
  endtask

  task automatic send_flow(input logic [7:0] fid);
    for (int p = 0; p < 5; p++) begin
      send_pkt(3'(p), p, fid, pproto[p], plen[p], pbeats[p]);
      if (pbeats[p] < 31) idle(1);
    end
  endtask

  // Reference: plain byte search over the bytes of each packet that were delivered and lie below its length.
  task automatic expect_flow(input logic [7:0] fid);
    rec_t r;
    int   cnt, lim;
    logic found;
    r.fid = fid; r.hit = 1'b0; r.mask = '0; r.cnt = '0; r.fpkt = '0; r.foff = '0;
    r.cyc = last_cyc + 2;
    cnt = 0; found = 1'b0;
    for (int p = 0; p < 5; p++) begin
`ifdef SNI_SCAN_TCP_ONLY_EN
      if (pproto[p] != 8'd6) continue;
`endif
      lim = int'(plen[p]);
      if (lim > 8 * pbeats[p]) lim = 8 * pbeats[p];
      for (int off = 0; off + 3 <= lim; off++) begin
        if (pay[p][off] == PAT0 && pay[p][off+1] == PAT1 && pay[p][off+2] == PAT2) begin
          r.mask[p] = 1'b1;
          cnt++;
          if (!found) begin
            found  = 1'b1;
            r.fpkt = 3'(p);
            r.foff = 8'(off);
          end
        end
      end
    end
    r.cnt = (cnt > 255) ? 8'd255 : 8'(cnt);
    r.hit = (cnt > 0);
    exp_q.push_back(r);
  endtask

  task automatic check_records(input string tag);
    rec_t o, e;
    check({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " flow_id"}, 32'(o.fid), 32'(e.fid));
      check({tag, " hit"}, 32'(o.hit), 32'(e.hit));
      check({tag, " mask"}, 32'(o.mask), 32'(e.mask));
      check({tag, " cnt"}, 32'(o.cnt), 32'(e.cnt));
      check({tag, " first_pkt"}, 32'(o.fpkt), 32'(e.fpkt));
      check({tag, " first_off"}, 32'(o.foff), 32'(e.foff));
      check({tag, " cycle"}, 32'(o.cyc), 32'(e.cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_none(input int src);
    logic [7:0] b;
    for (int i = 0; i < 248; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == PAT0) b = 8'h00;
      pay[src][i] = b;
    end
  endtask

  task automatic fill_alpha(input int src);
    for (int i = 0; i < 248; i++) begin
      case ($urandom_range(0, 3))
        0:       pay[src][i] = PAT0;
        1:       pay[src][i] = PAT1;
        2:       pay[src][i] = PAT2;
        default: pay[src][i] = 8'h00;
      endcase
    end
  endtask

  task automatic put_pat(input int src, input int off);
    pay[src][off]   = PAT0;
    pay[src][off+1] = PAT1;
    pay[src][off+2] = PAT2;
  endtask

  task automatic setup_none(input logic [7:0] len, input logic [7:0] proto);
    for (int p = 0; p < 5; p++) begin
      fill_none(p);
      plen[p]   = len;
      pproto[p] = proto;
      pbeats[p] = 31;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, 32'(o_match_valid), 32'd0);
    check({tag, " flow_id"}, 32'(o_match_flow_id), 32'd0);
    check({tag, " hit"}, 32'(o_match_hit), 32'd0);
    check({tag, " mask"}, 32'(o_match_pkt_mask), 32'd0);
    check({tag, " cnt"}, 32'(o_match_cnt), 32'd0);
    check({tag, " first_pkt"}, 32'(o_match_first_pkt), 32'd0);
    check({tag, " first_off"}, 32'(o_match_first_off), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_pkt_data_valid = 1'b0; i_pkt_data = '0; i_pkt_len = '0;
    i_pkt_num = '0; i_pkt_protocol = '0; i_pkt_cycle_cnt = '0; i_flow_id = '0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    idle(2);

    // pattern at the very start of packet 0
    setup_none(8'd200, 8'd6); put_pat(0, 0);
    send_flow(8'h11); expect_flow(8'h11); idle(4); check_records("pkt0_start");

    // pattern straddling the first two payload beats of packet 2
    setup_none(8'd200, 8'd6); put_pat(2, 6);
    send_flow(8'h22); expect_flow(8'h22); idle(4); check_records("straddle");

    // last byte beyond length, then exactly at the length limit
    setup_none(8'd200, 8'd6); put_pat(1, 198);
    send_flow(8'h33); expect_flow(8'h33); idle(4); check_records("len_excl");
    setup_none(8'd200, 8'd6); put_pat(1, 197);
    send_flow(8'h34); expect_flow(8'h34); idle(4); check_records("len_incl");

    // two matches per packet, both ending in the same beat
    setup_none(8'd248, 8'd6);
    for (int p = 0; p < 5; p++) begin put_pat(p, 8*p + 10); put_pat(p, 8*p + 13); end
    send_flow(8'h44); expect_flow(8'h44); idle(4); check_records("twice");

    // dense pattern saturates the count
    setup_none(8'd248, 8'd6);
    for (int p = 0; p < 5; p++) for (int o = 0; o + 3 <= 248; o += 3) put_pat(p, o);
    send_flow(8'h55); expect_flow(8'h55); idle(4); check_records("saturate");

    // non-TCP packet carrying the only match
    setup_none(8'd200, 8'd6); pproto[0] = 8'd17; put_pat(0, 20);
    send_flow(8'h66); expect_flow(8'h66); idle(4); check_records("udp");

    // random flows
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 5; p++) begin
        fill_alpha(p);
        plen[p]   = 8'($urandom_range(0, 255));
        pproto[p] = ($urandom_range(0, 1) == 0) ? 8'd6 : 8'd17;
        pbeats[p] = 31;
      end
      send_flow(8'(8'h70 + f)); expect_flow(8'(8'h70 + f)); idle(3);
    end
    check_records("random");

    // truncated packets keep the bytes already received
    for (int p = 0; p < 5; p++) begin fill_alpha(p); plen[p] = 8'd240; pproto[p] = 8'd6; pbeats[p] = 31; end
    pbeats[1] = 8; pbeats[3] = 20;
    send_flow(8'h80); expect_flow(8'h80); idle(4); check_records("truncate");

    // out-of-sequence packets are ignored
    setup_none(8'd200, 8'd6); put_pat(2, 40);
    for (int i = 0; i + 3 <= 248; i += 3) put_pat(5, i);
    send_pkt(3'd0, 0, 8'h90, 8'd6, 8'd200, 31);
    send_pkt(3'd1, 1, 8'h90, 8'd6, 8'd200, 31);
    send_pkt(3'd3, 5, 8'h90, 8'd6, 8'd200, 31);
    send_pkt(3'd1, 5, 8'h90, 8'd6, 8'd200, 31);
    for (int p = 2; p < 5; p++) send_pkt(3'(p), p, 8'h90, 8'd6, 8'd200, 31);
    expect_flow(8'h90); idle(4); check_records("out_of_seq");

    // back-to-back flows: next flow starts one and two cycles after the last beat
    for (int p = 0; p < 5; p++) begin fill_alpha(p); plen[p] = 8'd248; pproto[p] = 8'd6; pbeats[p] = 31; end
    send_flow(8'hA1); expect_flow(8'hA1);
    for (int p = 0; p < 5; p++) fill_alpha(p);
    send_flow(8'hA2); expect_flow(8'hA2);
    idle(1);
    setup_none(8'd100, 8'd6); put_pat(4, 50);
    send_flow(8'hA3); expect_flow(8'hA3); idle(4); check_records("back2back");

    // restart during packet 3 abandons the flow
    for (int p = 0; p < 5; p++) begin fill_alpha(p); plen[p] = 8'd248; pproto[p] = 8'd6; pbeats[p] = 31; end
    for (int p = 0; p < 3; p++) send_pkt(3'(p), p, 8'hB1, 8'd6, 8'd248, 31);
    send_pkt(3'd3, 3, 8'hB1, 8'd6, 8'd248, 10);
    setup_none(8'd200, 8'd6); put_pat(3, 100);
    send_flow(8'hB2); expect_flow(8'hB2); idle(4); check_records("abandon");

    // reset mid-flow drops the flow and clears the held record
    for (int p = 0; p < 5; p++) begin fill_alpha(p); plen[p] = 8'd248; pproto[p] = 8'd6; pbeats[p] = 31; end
    for (int p = 0; p < 2; p++) send_pkt(3'(p), p, 8'hC1, 8'd6, 8'd248, 31);
    send_pkt(3'd2, 2, 8'hC1, 8'd6, 8'd248, 5);
    i_pkt_data_valid = 1'b0; i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_reset_outputs("midreset");
    setup_none(8'd200, 8'd6); put_pat(0, 0); put_pat(4, 190);
    send_flow(8'hC2); expect_flow(8'hC2); idle(4); check_records("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
